// File: rtl/pa_fcnvt_ftoi_rnd_if.sv
// Handshake/data bundle between the FTOI shifter, the rounding stage and the FPU result mux.
interface pa_fcnvt_ftoi_rnd_if #(
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic             in_sign;
    logic [31:0]      in_v_nm;
    logic [24:0]      in_x_nm;
    logic [2:0]       in_rm;
    logic             in_unsigned;
    logic             in_nan;
    logic             in_inf;
    logic             in_ovf;
    logic [TAG_W-1:0] in_tag;
    logic             out_vld;
    logic             out_rdy;
    logic [31:0]      out_data;
    logic             out_nv;
    logic             out_nx;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_vld, in_sign, in_v_nm, in_x_nm, in_rm, in_unsigned,
               in_nan, in_inf, in_ovf, in_tag, out_rdy,
        input  in_rdy, out_vld, out_data, out_nv, out_nx, out_tag
    );

    modport slave (
        input  flush, in_vld, in_sign, in_v_nm, in_x_nm, in_rm, in_unsigned,
               in_nan, in_inf, in_ovf, in_tag, out_rdy,
        output in_rdy, out_vld, out_data, out_nv, out_nx, out_tag
    );
endinterface

// File: rtl/pa_fcnvt_ftoi_rnd.sv
// FTOI rounding/saturation: S1 applies the rounding increment, S2 negates and saturates
// into a 32-bit W/WU result with NV/NX, behind a two-stage valid/ready pipe.
module pa_fcnvt_ftoi_rnd #(
    parameter int TAG_W = 4
) (
    input logic              cpuclk,
    input logic              cpurst_b,
    pa_fcnvt_ftoi_rnd_if.slave bus
);
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [32:0]      s1_mag_q, s1_mag_d;
    logic             s1_nx_q, s1_nx_d, s1_sign_q, s1_sign_d, s1_uns_q, s1_uns_d;
    logic             s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d, s1_ovf_q, s1_ovf_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_nv_q, out_nv_d, out_nx_q, out_nx_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic s1_adv, s2_adv, s1_load, s2_load;
    logic g, s, inc;
    logic [31:0] pos_sat, neg_sat, res_data;
    logic res_nv, res_nx;

    always_comb begin
        s2_adv  = ~s2_vld_q | bus.out_rdy;
        s1_adv  = ~s1_vld_q | s2_adv;
        s1_load = bus.in_vld & s1_adv & ~bus.flush;
        s2_load = s1_vld_q & s2_adv & ~bus.flush;
        s1_vld_d = bus.flush ? 1'b0 : (s1_adv ? bus.in_vld : s1_vld_q);
        s2_vld_d = bus.flush ? 1'b0 : (s2_adv ? s1_vld_q : s2_vld_q);
    end

    // S1: rounding increment; mag is 33 bits so 0xFFFFFFFF+1 still saturates in S2
    always_comb begin
        g   = bus.in_x_nm[24];
        s   = |bus.in_x_nm[23:0];
        inc = 1'b0;
        case (bus.in_rm)
            RM_RNE:  inc = g & (s | bus.in_v_nm[0]);
            RM_RDN:  inc = bus.in_sign & (g | s);
            RM_RUP:  inc = ~bus.in_sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = 1'b0;
        endcase
        s1_mag_d  = s1_load ? ({1'b0, bus.in_v_nm} + {32'b0, inc}) : s1_mag_q;
        s1_nx_d   = s1_load ? (g | s) : s1_nx_q;
        s1_sign_d = s1_load ? bus.in_sign : s1_sign_q;
        s1_uns_d  = s1_load ? bus.in_unsigned : s1_uns_q;
        s1_nan_d  = s1_load ? bus.in_nan : s1_nan_q;
        s1_inf_d  = s1_load ? bus.in_inf : s1_inf_q;
        s1_ovf_d  = s1_load ? bus.in_ovf : s1_ovf_q;
        s1_tag_d  = s1_load ? bus.in_tag : s1_tag_q;
    end

    // S2: NaN saturates positive regardless of sign; invalid results never report NX
    always_comb begin
        pos_sat  = s1_uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        neg_sat  = s1_uns_q ? 32'h0000_0000 : 32'h8000_0000;
        res_data = s1_sign_q ? (32'd0 - s1_mag_q[31:0]) : s1_mag_q[31:0];
        res_nv   = 1'b1;
        res_nx   = 1'b0;
        if (s1_nan_q) begin
            res_data = pos_sat;
        end else if (s1_inf_q | s1_ovf_q) begin
            res_data = s1_sign_q ? neg_sat : pos_sat;
        end else if (~s1_uns_q & ~s1_sign_q & (s1_mag_q > 33'h0_7FFF_FFFF)) begin
            res_data = 32'h7FFF_FFFF;
        end else if (~s1_uns_q & s1_sign_q & (s1_mag_q > 33'h0_8000_0000)) begin
            res_data = 32'h8000_0000;
        end else if (s1_uns_q & s1_sign_q & (s1_mag_q != 33'd0)) begin
            res_data = 32'h0000_0000;
        end else if (s1_uns_q & ~s1_sign_q & s1_mag_q[32]) begin
            res_data = 32'hFFFF_FFFF;
        end else begin
            res_nv = 1'b0;
            res_nx = s1_nx_q;
        end
        out_data_d = s2_load ? res_data : out_data_q;
        out_nv_d   = s2_load ? res_nv : out_nv_q;
        out_nx_d   = s2_load ? res_nx : out_nx_q;
        out_tag_d  = s2_load ? s1_tag_q : out_tag_q;
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_mag_q   <= '0;
            s1_nx_q    <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_uns_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s1_tag_q   <= '0;
            out_data_q <= '0;
            out_nv_q   <= 1'b0;
            out_nx_q   <= 1'b0;
            out_tag_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s1_mag_q   <= s1_mag_d;
            s1_nx_q    <= s1_nx_d;
            s1_sign_q  <= s1_sign_d;
            s1_uns_q   <= s1_uns_d;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_ovf_q   <= s1_ovf_d;
            s1_tag_q   <= s1_tag_d;
            out_data_q <= out_data_d;
            out_nv_q   <= out_nv_d;
            out_nx_q   <= out_nx_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign bus.in_rdy   = s1_adv;
    assign bus.out_vld  = s2_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_nv   = out_nv_q;
    assign bus.out_nx   = out_nx_q;
    assign bus.out_tag  = out_tag_q;
endmodule

// File: tb/tb_pa_fcnvt_ftoi_rnd.sv
// Directed vectors for the FTOI rounding stage; expected results queued at accept, checked by a monitor.
module tb_pa_fcnvt_ftoi_rnd;
    typedef struct packed {
        logic [31:0] data;
        logic        nv;
        logic        nx;
        logic [3:0]  tag;
    } exp_t;

    logic cpuclk = 1'b0;
    logic cpurst_b = 1'b0;
    logic acc_q = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] tag_ctr = 4'd0;
    exp_t q[$];

    pa_fcnvt_ftoi_rnd_if #(.TAG_W(4)) ifc ();
    pa_fcnvt_ftoi_rnd #(.TAG_W(4)) dut (.cpuclk(cpuclk), .cpurst_b(cpurst_b), .bus(ifc.slave));

    always #5 cpuclk = ~cpuclk;
    always @(posedge cpuclk) acc_q <= ifc.in_vld & ifc.in_rdy & ~ifc.flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge cpuclk) begin
        if (cpurst_b && ifc.out_vld && ifc.out_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {32'd0, ifc.out_data}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("result_tag%0d", e.tag),
                    {26'd0, ifc.out_data, ifc.out_nv, ifc.out_nx, ifc.out_tag},
                    {26'd0, e.data, e.nv, e.nx, e.tag});
            end
        end
    end

    // Advance n cycles, ending 2 time units after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge cpuclk);
        #2;
    endtask

    task automatic send(input logic sgn, input logic [31:0] v, input logic [24:0] x,
                        input logic [2:0] rm, input logic uns, input logic nan,
                        input logic inf, input logic ovf,
                        input logic [31:0] ed, input logic env, input logic enx);
        bit ok = 0;
        ifc.in_vld = 1'b1; ifc.in_sign = sgn; ifc.in_v_nm = v; ifc.in_x_nm = x;
        ifc.in_rm = rm; ifc.in_unsigned = uns; ifc.in_nan = nan; ifc.in_inf = inf;
        ifc.in_ovf = ovf; ifc.in_tag = tag_ctr;
        for (int i = 0; i < 50; i++) begin
            @(posedge cpuclk);
            #1;
            if (acc_q) begin
                q.push_back('{data: ed, nv: env, nx: enx, tag: tag_ctr});
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        tag_ctr++;
        #1 ifc.in_vld = 1'b0;
    endtask

    initial begin
        ifc.flush = 0; ifc.in_vld = 0; ifc.in_sign = 0; ifc.in_v_nm = 0; ifc.in_x_nm = 0;
        ifc.in_rm = 0; ifc.in_unsigned = 0; ifc.in_nan = 0; ifc.in_inf = 0; ifc.in_ovf = 0;
        ifc.in_tag = 0; ifc.out_rdy = 1;
        #22;
        chk("reset_out_vld", {63'd0, ifc.out_vld}, 64'd0);
        chk("reset_out", {26'd0, ifc.out_data, ifc.out_nv, ifc.out_nx, ifc.out_tag}, 64'd0);
        chk("reset_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
        cpurst_b = 1'b1;
        cyc(1);

        // +2.5 W RNE: result two cycles after the accept cycle
        send(0, 32'd2, 25'h1000000, 3'd0, 0, 0, 0, 0, 32'h2, 0, 1);
        chk("latency_s1_only", {63'd0, ifc.out_vld}, 64'd0);
        cyc(1);
        chk("latency_out", {31'd0, ifc.out_vld, ifc.out_data}, {31'd0, 1'b1, 32'h2});
        send(0, 32'd2, 25'h1000000, 3'd4, 0, 0, 0, 0, 32'h3, 0, 1);
        send(0, 32'd2, 25'h1000000, 3'd3, 0, 0, 0, 0, 32'h3, 0, 1);
        send(1, 32'd2, 25'h1000000, 3'd2, 0, 0, 0, 0, 32'hFFFFFFFD, 0, 1);
        send(1, 32'd2, 25'h1000000, 3'd1, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 1);
        send(1, 32'd3, 25'h0,       3'd0, 0, 0, 0, 0, 32'hFFFFFFFD, 0, 0);
        send(0, 32'h80000000, 25'h0, 3'd1, 0, 0, 0, 0, 32'h7FFFFFFF, 1, 0);
        send(1, 32'h80000000, 25'h0, 3'd1, 0, 0, 0, 0, 32'h80000000, 0, 0);
        send(0, 32'h80000000, 25'h0, 3'd1, 1, 0, 0, 0, 32'h80000000, 0, 0);
        send(1, 32'd0, 25'h1800000, 3'd1, 1, 0, 0, 0, 32'h0, 0, 1);
        send(1, 32'd0, 25'h1800000, 3'd0, 1, 0, 0, 0, 32'h0, 1, 0);
        send(0, 32'd0, 25'h0,       3'd0, 1, 1, 0, 0, 32'hFFFFFFFF, 1, 0);
        send(1, 32'd7, 25'h1,       3'd0, 0, 1, 0, 0, 32'h7FFFFFFF, 1, 0);
        send(0, 32'hFFFFFFFF, 25'h1000000, 3'd0, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 0);
        send(1, 32'd0, 25'h0,       3'd0, 0, 0, 1, 0, 32'h80000000, 1, 0);
        send(1, 32'd5, 25'h0,       3'd0, 1, 0, 0, 1, 32'h0, 1, 0);
        send(0, 32'd5, 25'h0,       3'd0, 0, 0, 0, 1, 32'h7FFFFFFF, 1, 0);
        send(1, 32'd0, 25'h0,       3'd0, 0, 0, 0, 0, 32'h0, 0, 0);
        send(1, 32'd0, 25'h0800000, 3'd2, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 1);
        send(0, 32'd3, 25'h1000000, 3'd0, 0, 0, 0, 0, 32'h4, 0, 1);
        send(0, 32'd2, 25'h1000000, 3'd7, 0, 0, 0, 0, 32'h2, 0, 1);
        send(1, 32'h80000000, 25'h1000000, 3'd2, 0, 0, 0, 0, 32'h80000000, 1, 0);
        send(0, 32'd0, 25'h0000001, 3'd3, 1, 0, 0, 0, 32'h1, 0, 1);
        cyc(3);

        // Backpressure: two ops fill the pipe, the third waits until out_rdy returns
        ifc.out_rdy = 0;
        send(0, 32'd10, 25'h0, 3'd0, 0, 0, 0, 0, 32'd10, 0, 0);
        send(1, 32'd11, 25'h0, 3'd0, 0, 0, 0, 0, 32'hFFFFFFF5, 0, 0);
        ifc.in_vld = 1; ifc.in_sign = 0; ifc.in_v_nm = 32'd12; ifc.in_x_nm = 0;
        ifc.in_unsigned = 0; ifc.in_nan = 0; ifc.in_inf = 0; ifc.in_ovf = 0;
        cyc(1);
        chk("stall_in_rdy_a", {63'd0, ifc.in_rdy}, 64'd0);
        cyc(1);
        chk("stall_in_rdy_b", {63'd0, ifc.in_rdy}, 64'd0);
        chk("stall_hold", {31'd0, ifc.out_vld, ifc.out_data}, {31'd0, 1'b1, 32'd10});
        ifc.out_rdy = 1;
        send(0, 32'd12, 25'h0, 3'd0, 0, 0, 0, 0, 32'd12, 0, 0);
        cyc(3);

        // Flush with both stages full, then again with the pipe empty and in_vld high
        ifc.out_rdy = 0;
        send(0, 32'd20, 25'h0, 3'd0, 0, 0, 0, 0, 32'd20, 0, 0);
        send(0, 32'd21, 25'h0, 3'd0, 0, 0, 0, 0, 32'd21, 0, 0);
        ifc.flush = 1; ifc.in_vld = 1; ifc.in_v_nm = 32'd22;
        cyc(1);
        chk("flush_out_vld", {63'd0, ifc.out_vld}, 64'd0);
        chk("flush_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
        cyc(1);
        ifc.flush = 0; ifc.in_vld = 0;
        q.delete();
        ifc.out_rdy = 1;
        cyc(3);
        chk("flush_dropped", {63'd0, ifc.out_vld}, 64'd0);
        send(0, 32'd23, 25'h0, 3'd0, 0, 0, 0, 0, 32'd23, 0, 0);
        cyc(3);

        // Asynchronous reset mid-op
        ifc.out_rdy = 0;
        send(0, 32'd30, 25'h0, 3'd0, 0, 0, 0, 0, 32'd30, 0, 0);
        cyc(1);
        chk("pre_reset_vld", {63'd0, ifc.out_vld}, 64'd1);
        #2 cpurst_b = 0;
        #1;
        chk("async_rst_vld", {63'd0, ifc.out_vld}, 64'd0);
        chk("async_rst_data", {32'd0, ifc.out_data}, 64'd0);
        q.delete();
        cyc(1);
        cpurst_b = 1;
        #1;
        chk("post_rst_in_rdy", {63'd0, ifc.in_rdy}, 64'd1);
        ifc.out_rdy = 1;
        cyc(1);
        send(1, 32'd1, 25'h1000000, 3'd4, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 1);

        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
        chk("drain", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
